inst_encoder: RTL

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// Encodes mnemonic-indexed requests into MIPS32 instruction words and buffers them
// in a 2-entry FIFO; also counts delivered words and dropped illegal requests.
module inst_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_mnem,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        err,
    output logic [15:0] word_cnt,
    output logic [7:0]  err_cnt
);
    localparam logic [5:0] EXE_AND    = 6'b100100, EXE_OR    = 6'b100101;
    localparam logic [5:0] EXE_XOR    = 6'b100110, EXE_NOR   = 6'b100111;
    localparam logic [5:0] EXE_SLL    = 6'b000000, EXE_SRL   = 6'b000010;
    localparam logic [5:0] EXE_SRA    = 6'b000011, EXE_SLLV  = 6'b000100;
    localparam logic [5:0] EXE_SRLV   = 6'b000110, EXE_SRAV  = 6'b000111;
    localparam logic [5:0] EXE_ADD    = 6'b100000, EXE_ADDU  = 6'b100001;
    localparam logic [5:0] EXE_SUB    = 6'b100010, EXE_SUBU  = 6'b100011;
    localparam logic [5:0] EXE_SLT    = 6'b101010, EXE_SLTU  = 6'b101011;
    localparam logic [5:0] EXE_MULT   = 6'b011000, EXE_MULTU = 6'b011001;
    localparam logic [5:0] EXE_DIV    = 6'b011010, EXE_DIVU  = 6'b011011;
    localparam logic [5:0] EXE_MFHI   = 6'b010000, EXE_MFLO  = 6'b010010;
    localparam logic [5:0] EXE_MTHI   = 6'b010001, EXE_MTLO  = 6'b010011;
    localparam logic [5:0] EXE_ANDI   = 6'b001100, EXE_XORI  = 6'b001110;
    localparam logic [5:0] EXE_LUI    = 6'b001111, EXE_ORI   = 6'b001101;
    localparam logic [5:0] EXE_ADDI   = 6'b001000, EXE_ADDIU = 6'b001001;
    localparam logic [5:0] EXE_SLTI   = 6'b001010, EXE_SLTIU = 6'b001011;
    localparam logic [5:0] EXE_BEQ    = 6'b000100, EXE_BNE   = 6'b000101;
    localparam logic [5:0] EXE_BGTZ   = 6'b000111, EXE_BLEZ  = 6'b000110;
    localparam logic [5:0] EXE_LW     = 6'b100011, EXE_SW    = 6'b101011;
    localparam logic [5:0] EXE_J      = 6'b000010, EXE_JAL   = 6'b000011;
    localparam logic [5:0] EXE_REGIMM = 6'b000001;
    localparam logic [4:0] EXE_BLTZ   = 5'b00000,  EXE_BGEZ  = 5'b00001;
    localparam logic [4:0] EXE_BLTZAL = 5'b10000,  EXE_BGEZAL = 5'b10001;

    typedef enum logic [1:0] {FmtR, FmtI, FmtRegimm, FmtJ} fmt_e;

    fmt_e        w_fmt;
    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_sh;
    logic        w_legal, w_accept, w_push, w_pop;
    logic [31:0] w_word;

    logic [1:0]  r_count;
    logic [31:0] r_data0, r_data1;
    logic        r_err;
    logic [15:0] r_word_cnt;
    logic [7:0]  r_err_cnt;

    always_comb begin
        w_fmt   = FmtR;
        w_op    = 6'b000000;
        w_funct = 6'b000000;
        w_rs    = in_rs;
        w_rt    = in_rt;
        w_rd    = in_rd;
        w_sh    = 5'd0;
        w_legal = 1'b1;
        case (in_mnem)
            6'd0:  w_funct = EXE_AND;
            6'd1:  w_funct = EXE_OR;
            6'd2:  w_funct = EXE_XOR;
            6'd3:  w_funct = EXE_NOR;
            6'd4:  begin w_funct = EXE_SLL; w_rs = 5'd0; w_sh = in_shamt; end
            6'd5:  begin w_funct = EXE_SRL; w_rs = 5'd0; w_sh = in_shamt; end
            6'd6:  begin w_funct = EXE_SRA; w_rs = 5'd0; w_sh = in_shamt; end
            6'd7:  w_funct = EXE_SLLV;
            6'd8:  w_funct = EXE_SRLV;
            6'd9:  w_funct = EXE_SRAV;
            6'd10: w_funct = EXE_ADD;
            6'd11: w_funct = EXE_ADDU;
            6'd12: w_funct = EXE_SUB;
            6'd13: w_funct = EXE_SUBU;
            6'd14: w_funct = EXE_SLT;
            6'd15: w_funct = EXE_SLTU;
            6'd16: begin w_funct = EXE_MULT;  w_rd = 5'd0; end
            6'd17: begin w_funct = EXE_MULTU; w_rd = 5'd0; end
            6'd18: begin w_funct = EXE_DIV;   w_rd = 5'd0; end
            6'd19: begin w_funct = EXE_DIVU;  w_rd = 5'd0; end
            6'd20: begin w_funct = EXE_MFHI; w_rs = 5'd0; w_rt = 5'd0; end
            6'd21: begin w_funct = EXE_MFLO; w_rs = 5'd0; w_rt = 5'd0; end
            6'd22: begin w_funct = EXE_MTHI; w_rt = 5'd0; w_rd = 5'd0; end
            6'd23: begin w_funct = EXE_MTLO; w_rt = 5'd0; w_rd = 5'd0; end
            6'd24: begin w_fmt = FmtI; w_op = EXE_ANDI; end
            6'd25: begin w_fmt = FmtI; w_op = EXE_XORI; end
            6'd26: begin w_fmt = FmtI; w_op = EXE_LUI; w_rs = 5'd0; end
            6'd27: begin w_fmt = FmtI; w_op = EXE_ORI; end
            6'd28: begin w_fmt = FmtI; w_op = EXE_ADDI; end
            6'd29: begin w_fmt = FmtI; w_op = EXE_ADDIU; end
            6'd30: begin w_fmt = FmtI; w_op = EXE_SLTI; end
            6'd31: begin w_fmt = FmtI; w_op = EXE_SLTIU; end
            6'd32: begin w_fmt = FmtI; w_op = EXE_BEQ; end
            6'd33: begin w_fmt = FmtI; w_op = EXE_BNE; end
            6'd34: begin w_fmt = FmtI; w_op = EXE_BGTZ; w_rt = 5'd0; end
            6'd35: begin w_fmt = FmtI; w_op = EXE_BLEZ; w_rt = 5'd0; end
            6'd36: begin w_fmt = FmtRegimm; w_rt = EXE_BLTZ; end
            6'd37: begin w_fmt = FmtRegimm; w_rt = EXE_BGEZ; end
            6'd38: begin w_fmt = FmtRegimm; w_rt = EXE_BLTZAL; end
            6'd39: begin w_fmt = FmtRegimm; w_rt = EXE_BGEZAL; end
            6'd40: begin w_fmt = FmtI; w_op = EXE_LW; end
            6'd41: begin w_fmt = FmtI; w_op = EXE_SW; end
            6'd42: begin w_fmt = FmtJ; w_op = EXE_J; end
            6'd43: begin w_fmt = FmtJ; w_op = EXE_JAL; end
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (w_fmt)
            FmtR:      w_word = {6'b000000, w_rs, w_rt, w_rd, w_sh, w_funct};
            FmtI:      w_word = {w_op, w_rs, w_rt, in_imm};
            FmtRegimm: w_word = {EXE_REGIMM, w_rs, w_rt, in_imm};
            default:   w_word = {w_op, in_target};
        endcase
    end

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign in_ready  = !rst && ((r_count != 2'd2) || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_accept && w_legal;
    assign out_valid = (r_count != 2'd0);
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= 2'd0;
            r_data0    <= 32'd0;
            r_data1    <= 32'd0;
            r_err      <= 1'b0;
            r_word_cnt <= 16'd0;
            r_err_cnt  <= 8'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_data0 <= w_word;
                    else                 r_data1 <= w_word;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_data0 <= w_word;
                    end else begin
                        r_data0 <= r_data1;
                        r_data1 <= w_word;
                    end
                end
                default: ;
            endcase
            r_err <= w_accept && !w_legal;
            if (w_accept && !w_legal && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
            if (w_pop) r_word_cnt <= r_word_cnt + 16'd1;
        end
    end

    assign out_word = r_data0;
    assign err      = r_err;
    assign word_cnt = r_word_cnt;
    assign err_cnt  = r_err_cnt;

endmodule
